// File: rtl/input_debouncer.sv
// Per-bit synchroniser and consecutive-sample debouncer for raw pad inputs.
// Produces clean levels plus registered one-cycle rise/fall strobes.
module input_debouncer #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  db_q, db_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  sync_last;
    logic                              stable_c;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = raw_in;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_comb begin
        db_d     = db_q;
        cnt_d    = cnt_q;
        rise_d   = '0;
        fall_d   = '0;
        stable_c = 1'b1;
        for (int b = 0; b < int'(WIDTH); b++) begin
            // A match always clears the count, so short glitches leave no residue.
            if (sync_last[b] == db_q[b]) begin
                cnt_d[b] = '0;
            end else if (tick) begin
                if (cnt_q[b] == CntMax) begin
                    db_d[b]   = sync_last[b];
                    cnt_d[b]  = '0;
                    rise_d[b] = sync_last[b];
                    fall_d[b] = ~sync_last[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
            if ((sync_last[b] != db_q[b]) || (cnt_q[b] != '0)) begin
                stable_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign stable = stable_c;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed scoreboard bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_input_debouncer;

    localparam int unsigned W  = 3;
    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;
    localparam int          Lat = SS + DC - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick;
    logic [W-1:0] raw_in;
    logic [W-1:0] db_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         stable;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] db;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        logic         st;
        bit           chk_st;
    } exp_t;

    exp_t exp_q[$];

    input_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .raw_in (raw_in),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .stable (stable)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [W-1:0] db, input logic [W-1:0] rs,
                        input logic [W-1:0] fl, input logic st, input bit chk_st);
        exp_t e;
        e.tag    = tag;
        e.db     = db;
        e.rs     = rs;
        e.fl     = fl;
        e.st     = st;
        e.chk_st = chk_st;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then compare the DUT against the oldest queued expectation.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_db"}, 32'(db_out), 32'(e.db));
            check_eq({e.tag, "_rise"}, 32'(rise), 32'(e.rs));
            check_eq({e.tag, "_fall"}, 32'(fall), 32'(e.fl));
            if (e.chk_st) check_eq({e.tag, "_stable"}, 32'(stable), 32'(e.st));
        end
    endtask

    // Hold a new level with tick=1 and expect the change exactly Lat edges later.
    task automatic press(input string tag, input logic [W-1:0] old_v, input logic [W-1:0] new_v);
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        tick   = 1'b1;
        raw_in = new_v;
        for (int k = 0; k <= Lat + 2; k++) begin
            rs = (k == Lat) ? (new_v & ~old_v) : '0;
            fl = (k == Lat) ? (old_v & ~new_v) : '0;
            push($sformatf("%s_e%0d", tag, k), (k >= Lat) ? new_v : old_v, rs, fl,
                 !(k >= int'(SS) && k < Lat), k != int'(SS) - 1);
            step();
        end
    endtask

    initial begin
        int  seen;
        int  upd;
        bit  tk;

        rst    = 1'b1;
        tick   = 1'b1;
        raw_in = '0;
        for (int k = 0; k < 2; k++) begin
            push($sformatf("rst_e%0d", k), '0, '0, '0, 1'b1, 1'b1);
            step();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("idle_e%0d", k), '0, '0, '0, 1'b1, 1'b1);
            step();
        end

        press("press0", 3'b000, 3'b001);
        press("rel0", 3'b001, 3'b000);

        // Three-clock glitch on bit 1 must be rejected.
        for (int k = 0; k < 10; k++) begin
            raw_in = (k < 3) ? 3'b010 : 3'b000;
            push($sformatf("glitch_e%0d", k), '0, '0, '0, !(k >= 2 && k <= 4), k != 1);
            step();
        end

        // Prescaled: bit 2 drops after three ticks, so the count must clear.
        for (int k = 0; k < 18; k++) begin
            tick   = (k % 3 == 0);
            raw_in = (k < 10) ? 3'b100 : 3'b000;
            push($sformatf("pclr_e%0d", k), '0, '0, '0, !(k >= 2 && k <= 11), k != 1);
            step();
        end

        // Prescaled press: change lands on the DC-th tick seen while mismatched.
        seen = 0;
        upd  = -1;
        raw_in = 3'b100;
        for (int k = 0; k < 16; k++) begin
            tk   = (k % 3 == 0);
            tick = tk;
            if (tk && k >= int'(SS) && upd < 0) begin
                seen++;
                if (seen == int'(DC)) upd = k;
            end
            push($sformatf("ppress_e%0d", k), (upd >= 0) ? 3'b100 : 3'b000,
                 (upd == k) ? 3'b100 : 3'b000, '0, !(k >= 1 && upd < 0), k != 1);
            step();
        end
        check_eq("ppress_upd_edge", 32'(upd), 32'd12);

        press("rel2", 3'b100, 3'b000);
        press("sim_r", 3'b000, 3'b101);
        press("sim_f", 3'b101, 3'b000);

        // Reset pulse at edge 3 mid-count; latency restarts from edge 4.
        tick   = 1'b1;
        raw_in = 3'b001;
        for (int k = 0; k <= 10; k++) begin
            rst = (k == 3);
            push($sformatf("rstmid_e%0d", k), (k >= 9) ? 3'b001 : 3'b000,
                 (k == 9) ? 3'b001 : 3'b000, '0,
                 !((k == 2) || (k >= 6 && k <= 8)), (k != 1) && (k != 5));
            step();
        end
        rst = 1'b0;

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream input-conditioning stage for the A/B/C logic-gate circuit.
- Synchronises WIDTH raw asynchronous pad inputs (ui_in[2:0] → A, B, C) into clk.
- Debounces each bit independently with a per-bit consecutive-sample counter.
- Presents clean levels plus one-cycle rise/fall strobes to the downstream combinational logic and any future event logic.

Parameters:
- WIDTH, 3: number of independent input bits.
- SYNC_STAGES, 2: synchroniser flop depth per bit. Legal range ≥2.
- DEBOUNCE_CYCLES, 16: consecutive qualifying ticks a new level must persist before it is accepted. Legal range ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): per-bit counter width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  sample-enable prescale strobe. Tie to 1 for per-clock debouncing.
- raw_in  in  WIDTH  asynchronous raw inputs.
- db_out  out  WIDTH  debounced level. Bits [0], [1], [2] feed A, B, C.
- rise  out  WIDTH  one-cycle pulse when a db_out bit goes 0→1.
- fall  out  WIDTH  one-cycle pulse when a db_out bit goes 1→0.
- stable  out  1  high when every bit's synced input equals db_out and every counter is 0.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). All state updates on the rising edge of clk only.
- Reset values:
  - All synchroniser flops, db_out, counters, rise and fall = 0.
  - stable = 1 from the first edge after reset, provided raw_in is low.
- Synchroniser: per-bit SYNC_STAGES flop chain. sync_q is the last stage. No logic between stages.
- Per-bit counter, evaluated each edge in this priority order:
  1. sync_q == db_out: counter ← 0, regardless of tick. This is glitch rejection.
  2. Mismatch and tick = 0: counter holds.
  3. Mismatch, tick = 1, counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  4. Mismatch, tick = 1, counter == DEBOUNCE_CYCLES−1: db_out bit ← sync_q, counter ← 0. Pulse rise or fall for that bit on the same edge.
- Strobes:
  - rise and fall are registered and high for exactly one clk cycle.
  - They are never both high for the same bit.
  - Bits are fully independent; simultaneous events on several bits produce simultaneous strobes.
- Latency (tick = 1):
  - Edge 0 is the first edge that samples the new raw level.
  - db_out changes at edge SYNC_STAGES+DEBOUNCE_CYCLES−1, i.e. edge 17 for the defaults.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES qualifying ticks at sync_q produces no change and no strobe.
- Tick handling:
  - With a slow tick, only ticks during a continuous mismatch count.
  - A return to match between ticks clears the counter.
- Counter never exceeds DEBOUNCE_CYCLES−1. No wrap-around is possible.
- Reset mid-count: counters, sync chain and db_out are cleared on that edge. No strobe is issued on the reset edge or the edge after it.
- stable is combinational from registered state: stable = AND over bits of (sync_q == db_out && counter == 0).
- The block introduces no combinational path from raw_in to any output.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 for the bench):
- Reset then idle: rst=1 for 2 cycles, raw_in=000 → db_out=000, rise=fall=000, stable=1 continuously.
- Clean press: raw_in[0] 0→1 held, tick=1 → db_out[0]=1 at edge 5; rise[0]=1 for exactly that one cycle; stable=0 from edge 2 to edge 4.
- Glitch reject: raw_in[1]=1 for 3 clocks then 0, tick=1 → db_out stays 000, no strobes, stable returns to 1.
- Prescaled: tick high every 3rd clock, raw_in[2] 0→1 held → db_out[2] changes only after 4 ticks seen with sync_q mismatched. Dropping raw_in between ticks clears the count.
- Simultaneous: raw_in 000→101 → rise=101 in one cycle at edge 5. Later 101→000 → fall=101 in one cycle.
- Reset mid-count: raw_in[0]=1, assert rst at edge 3 for 1 cycle → db_out=000, no rise. After release, the full 5-edge latency restarts from the sync chain.
